// File: rtl/sad_err_monitor_pkg.sv
// Shared types and default widths for the SAD response-side evaluation blocks.
package sad_eval_pkg;
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam int DEF_OUT_W = 3;
    localparam int DEF_CNT_W = 16;
endpackage

// File: rtl/sad_err_monitor_if.sv
// Control, sample-pair and result bundle between the evaluation driver and the error monitor.
interface sad_err_monitor_if
    import sad_eval_pkg::*;
#(
    parameter int OUT_W = DEF_OUT_W,
    parameter int CNT_W = DEF_CNT_W,
    parameter int SUM_W = CNT_W + OUT_W
);
    logic             start;
    logic [CNT_W-1:0] num_samples;
    logic             in_valid;
    logic             in_ready;
    logic [OUT_W-1:0] exact;
    logic [OUT_W-1:0] approx;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] sample_count;
    logic [CNT_W-1:0] err_count;
    logic [SUM_W-1:0] err_sum;
    logic [OUT_W-1:0] err_max;

    modport master (
        output start, num_samples, in_valid, exact, approx,
        input  in_ready, busy, done, sample_count, err_count, err_sum, err_max
    );

    modport slave (
        input  start, num_samples, in_valid, exact, approx,
        output in_ready, busy, done, sample_count, err_count, err_sum, err_max
    );
endinterface

// File: rtl/sad_err_monitor_abs_diff.sv
// Combinational unsigned |a - b|; also used by the stimulus-side exhaustive checker.
module sad_abs_diff #(
    parameter int OUT_W = 3
) (
    input  logic [OUT_W-1:0] a,
    input  logic [OUT_W-1:0] b,
    output logic [OUT_W-1:0] y
);
    logic [OUT_W:0] raw;
    logic [OUT_W:0] mag;

    // The extra MSB is the borrow; when set the raw difference is negated.
    assign raw = {1'b0, a} - {1'b0, b};
    assign mag = raw[OUT_W] ? (~raw + {{OUT_W{1'b0}}, 1'b1}) : raw;
    assign y   = mag[OUT_W-1:0];
endmodule

// File: rtl/sad_err_monitor.sv
// Accumulates mismatch count, error sum and worst-case error over a programmed run of pairs.
module sad_err_monitor
    import sad_eval_pkg::*;
#(
    parameter int OUT_W = DEF_OUT_W,
    parameter int CNT_W = DEF_CNT_W,
    parameter int SUM_W = CNT_W + OUT_W
) (
    input  logic              clk,
    input  logic              rst,
    sad_err_monitor_if.slave  mon
);
    state_e           state_q, state_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [CNT_W-1:0] num_q, num_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] errc_q, errc_d;
    logic [SUM_W-1:0] sum_q, sum_d;
    logic [OUT_W-1:0] max_q, max_d;
    logic [OUT_W-1:0] diff;
    logic             accept;

    sad_abs_diff #(.OUT_W(OUT_W)) u_abs_diff (
        .a (mon.exact),
        .b (mon.approx),
        .y (diff)
    );

    // in_ready is the registered busy flag, so accepts only happen in RUN.
    assign accept = busy_q && mon.in_valid;

    always_comb begin
        state_d = state_q;
        num_d   = num_q;
        cnt_d   = cnt_q;
        errc_d  = errc_q;
        sum_d   = sum_q;
        max_d   = max_q;
        case (state_q)
            IDLE: begin
                if (mon.start) begin
                    num_d   = mon.num_samples;
                    cnt_d   = '0;
                    errc_d  = '0;
                    sum_d   = '0;
                    max_d   = '0;
                    state_d = (mon.num_samples == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                if (accept) begin
                    cnt_d  = cnt_q + CNT_W'(1);
                    errc_d = errc_q + CNT_W'(diff != '0);
                    sum_d  = sum_q + SUM_W'(diff);
                    max_d  = (diff > max_q) ? diff : max_q;
                    if (cnt_d == num_q) begin
                        state_d = DONE;
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        busy_d = (state_d == RUN);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            num_q   <= '0;
            cnt_q   <= '0;
            errc_q  <= '0;
            sum_q   <= '0;
            max_q   <= '0;
        end else begin
            state_q <= state_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            num_q   <= num_d;
            cnt_q   <= cnt_d;
            errc_q  <= errc_d;
            sum_q   <= sum_d;
            max_q   <= max_d;
        end
    end

    assign mon.in_ready     = busy_q;
    assign mon.busy         = busy_q;
    assign mon.done         = done_q;
    assign mon.sample_count = cnt_q;
    assign mon.err_count    = errc_q;
    assign mon.err_sum      = sum_q;
    assign mon.err_max      = max_q;
endmodule

// File: tb/tb_sad_err_monitor.sv
// Directed runs through the error monitor; expected results queued per run, checked on each done pulse.
module tb_sad_err_monitor;
    localparam int OUT_W = 3;
    localparam int CNT_W = 16;
    localparam int SUM_W = CNT_W + OUT_W;

    typedef struct {
        string name;
        int    cnt;
        int    errc;
        int    sum;
        int    max;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   checks   = 0;
    int   failures = 0;
    int   dones    = 0;
    exp_t sb[$];

    sad_err_monitor_if #(.OUT_W(OUT_W), .CNT_W(CNT_W), .SUM_W(SUM_W)) bus ();

    sad_err_monitor #(.OUT_W(OUT_W), .CNT_W(CNT_W), .SUM_W(SUM_W)) dut (
        .clk (clk),
        .rst (rst),
        .mon (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic cmp(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    // Monitor: every done pulse consumes one expected result set.
    always @(negedge clk) begin
        exp_t e;
        if (!rst && bus.done) begin
            dones++;
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_done actual=1 required=0");
            end else begin
                e = sb.pop_front();
                $display("run %s: samples=%0d errs=%0d sum=%0d max=%0d", e.name,
                         bus.sample_count, bus.err_count, bus.err_sum, bus.err_max);
                cmp({e.name, "_sample_count"}, int'(bus.sample_count), e.cnt);
                cmp({e.name, "_err_count"},    int'(bus.err_count),    e.errc);
                cmp({e.name, "_err_sum"},      int'(bus.err_sum),      e.sum);
                cmp({e.name, "_err_max"},      int'(bus.err_max),      e.max);
            end
        end
    end

    task automatic tick(input int k);
        repeat (k) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push(input string name, input int c, input int ec, input int s, input int m);
        exp_t e;
        e.name = name; e.cnt = c; e.errc = ec; e.sum = s; e.max = m;
        sb.push_back(e);
    endtask

    task automatic start_run(input int n);
        bus.start       = 1'b1;
        bus.num_samples = CNT_W'(n);
        tick(1);
        bus.start       = 1'b0;
    endtask

    task automatic send(input int e, input int a);
        bus.in_valid = 1'b1;
        bus.exact    = OUT_W'(e);
        bus.approx   = OUT_W'(a);
        tick(1);
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int i = 0;
        while ((bus.busy || bus.done) && i < 20) begin
            tick(1);
            i++;
        end
        if (i == 20) begin
            checks++;
            failures++;
            $display("FAIL %s_timeout actual=busy required=idle", name);
        end
    endtask

    initial begin
        rst             = 1'b1;
        bus.start       = 1'b0;
        bus.num_samples = '0;
        bus.in_valid    = 1'b0;
        bus.exact       = '0;
        bus.approx      = '0;
        tick(2);
        cmp("reset_busy",     int'(bus.busy),         0);
        cmp("reset_in_ready", int'(bus.in_ready),     0);
        cmp("reset_done",     int'(bus.done),         0);
        cmp("reset_count",    int'(bus.sample_count), 0);
        cmp("reset_sum",      int'(bus.err_sum),      0);
        rst = 1'b0;
        tick(1);

        // Basic run: diffs 0,3,4,0.
        push("basic", 4, 2, 7, 4);
        start_run(4);
        send(3, 3); send(1, 4); send(6, 2); send(0, 0);
        wait_idle("basic");

        // Zero-length run goes straight to DONE without raising busy.
        push("zero", 0, 0, 0, 0);
        start_run(0);
        cmp("zero_busy",     int'(bus.busy),     0);
        cmp("zero_in_ready", int'(bus.in_ready), 0);
        wait_idle("zero");

        // Valid on cycles 1, 4, 6 only.
        push("gaps", 3, 2, 14, 7);
        start_run(3);
        send(7, 0); tick(2); send(0, 7); tick(1); send(5, 5);
        wait_idle("gaps");

        // A start pulse during RUN must not reload the sample count.
        push("start_ignored", 3, 3, 7, 4);
        start_run(3);
        send(1, 0);
        bus.start = 1'b1; bus.num_samples = CNT_W'(2);
        send(2, 0);
        bus.start = 1'b0;
        send(4, 0);
        wait_idle("start_ignored");

        // Reset after 2 of 5 samples discards the run with no done pulse.
        start_run(5);
        send(1, 2); send(3, 0);
        rst = 1'b1;
        tick(1);
        cmp("midrst_busy",     int'(bus.busy),         0);
        cmp("midrst_in_ready", int'(bus.in_ready),     0);
        cmp("midrst_done",     int'(bus.done),         0);
        cmp("midrst_count",    int'(bus.sample_count), 0);
        cmp("midrst_sum",      int'(bus.err_sum),      0);
        rst = 1'b0;
        tick(1);
        push("after_rst", 1, 1, 1, 1);
        start_run(1);
        send(2, 1);
        wait_idle("after_rst");

        // Back-to-back runs; symmetric diffs in the first, fresh totals in the second.
        push("b2b_a", 2, 2, 6, 3);
        start_run(2);
        send(2, 5); send(5, 2);
        tick(1);
        push("b2b_b", 2, 1, 1, 1);
        start_run(2);
        send(0, 1); send(1, 1);
        wait_idle("b2b_b");

        tick(3);
        cmp("queue_empty", sb.size(), 0);
        cmp("done_pulses", dones, 7);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
